// File: rtl/alu_arbiter_if.sv
// Signal bundle between alu_arbiter, its two requesters and the shared 4-phase ALU.
// slave = arbiter side, master = requesters plus ALU side.
interface alu_arbiter_if;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_dat1, req0_dat2, req1_dat1, req1_dat2;
    logic [5:0]  req0_instr, req1_instr;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_out, rsp1_out;
    logic [3:0]  rsp0_flags, rsp1_flags;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] ALU_dat1, ALU_dat2;
    logic [5:0]  Instruction_from_CU;
    logic [31:0] ALU_out;
    logic        ALU_overflow, ALU_con_met, ALU_zero, ALU_err;
    logic        ALU_ready, ALU_accept;

    modport slave (
        input  req0_valid, req1_valid, req0_dat1, req0_dat2, req1_dat1, req1_dat2,
               req0_instr, req1_instr, rsp0_ready, rsp1_ready,
               ALU_out, ALU_overflow, ALU_con_met, ALU_zero, ALU_err, ALU_ready, ALU_accept,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out, rsp1_out,
               rsp0_flags, rsp1_flags, ALU_dat1, ALU_dat2, Instruction_from_CU
    );

    modport master (
        output req0_valid, req1_valid, req0_dat1, req0_dat2, req1_dat1, req1_dat2,
               req0_instr, req1_instr, rsp0_ready, rsp1_ready,
               ALU_out, ALU_overflow, ALU_con_met, ALU_zero, ALU_err, ALU_ready, ALU_accept,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out, rsp1_out,
               rsp0_flags, rsp1_flags, ALU_dat1, ALU_dat2, Instruction_from_CU
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 4-phase ALU.
// Define ALU_ARB_TIMEOUT_EN to abort a silent ALU after TIMEOUT_CYCLES of ISSUE+WAIT.
//
// state | meaning
// IDLE  | no operation owned; grant on ALU phase 0
// ISSUE | registered operands driven to the ALU (ALU phase 1)
// WAIT  | waiting for ALU_ready (or timeout)
// RESP  | owner's response held until its rsp_ready
module alu_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic         soc_clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_owner, r_prio;
    logic [31:0] r_op_a, r_op_b;
    logic [5:0]  r_op_i;
    logic [31:0] r_rsp0_out, r_rsp1_out;
    logic [3:0]  r_rsp0_flags, r_rsp1_flags;

    logic        w_gnt_id, w_owner_rdy, w_free, w_grant, w_capture, w_timeout;
    logic [31:0] w_cap_out;
    logic [3:0]  w_cap_flags;

    // r_prio names the requester that wins when both are valid
    assign w_gnt_id    = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;
    assign w_owner_rdy = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    assign w_free      = (r_state == ST_IDLE) | ((r_state == ST_RESP) & w_owner_rdy);
    assign w_grant     = ~reset & w_free & bus.ALU_accept & (bus.req0_valid | bus.req1_valid);
    assign w_capture   = (r_state == ST_WAIT) & (bus.ALU_ready | w_timeout);
    assign w_cap_out   = bus.ALU_ready ? bus.ALU_out : 32'd0;
    assign w_cap_flags = bus.ALU_ready ?
                         {bus.ALU_err, bus.ALU_zero, bus.ALU_con_met, bus.ALU_overflow} : 4'b1000;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] r_to_cnt;

    // Loaded at grant so that terminal count lands on the last allowed ISSUE+WAIT cycle
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_grant) begin
            r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == '0) & ~bus.ALU_ready;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_capture) w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end else if (w_owner_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_prio       <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_i       <= '0;
            r_rsp0_out   <= '0;
            r_rsp1_out   <= '0;
            r_rsp0_flags <= '0;
            r_rsp1_flags <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_gnt_id;
                r_prio  <= ~w_gnt_id;
                r_op_a  <= w_gnt_id ? bus.req1_dat1  : bus.req0_dat1;
                r_op_b  <= w_gnt_id ? bus.req1_dat2  : bus.req0_dat2;
                r_op_i  <= w_gnt_id ? bus.req1_instr : bus.req0_instr;
            end
            if (w_capture) begin
                if (r_owner) begin
                    r_rsp1_out   <= w_cap_out;
                    r_rsp1_flags <= w_cap_flags;
                end else begin
                    r_rsp0_out   <= w_cap_out;
                    r_rsp0_flags <= w_cap_flags;
                end
            end
        end
    end

    always_comb begin
        bus.req0_ready          = w_grant & ~w_gnt_id;
        bus.req1_ready          = w_grant & w_gnt_id;
        bus.rsp0_valid          = (r_state == ST_RESP) & ~r_owner;
        bus.rsp1_valid          = (r_state == ST_RESP) & r_owner;
        bus.rsp0_out            = r_rsp0_out;
        bus.rsp1_out            = r_rsp1_out;
        bus.rsp0_flags          = r_rsp0_flags;
        bus.rsp1_flags          = r_rsp1_flags;
        bus.ALU_dat1            = '0;
        bus.ALU_dat2            = '0;
        bus.Instruction_from_CU = '0;
        // Zero operands and instruction code form the ALU NOP outside ISSUE
        if (r_state == ST_ISSUE) begin
            bus.ALU_dat1            = r_op_a;
            bus.ALU_dat2            = r_op_b;
            bus.Instruction_from_CU = r_op_i;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a cycle-level
// transaction model; timeout scenario follows ALU_ARB_TIMEOUT_EN.
module tb_alu_arbiter;
    localparam int TO = 8;

    logic soc_clk = 1'b0;
    logic reset;
    alu_arbiter_if bus();

    alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.soc_clk(soc_clk), .reset(reset), .bus(bus));

    always #5 soc_clk = ~soc_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // requester stimulus
    bit          v[2];
    logic [31:0] a[2], b[2];
    logic [5:0]  ins[2];
    bit          rr[2];
    bit          auto_new, rand_v, rr_rand;
    // ALU stub
    int          ph, alu_cnt, alu_extra_max;
    bit          alu_sup, stray_en;
    logic [31:0] alu_res;
    logic [3:0]  alu_fl;
    // reference model
    bit          m_busy, m_resp;
    int          m_owner, m_age, m_prio;
    logic [31:0] m_a, m_b;
    logic [5:0]  m_i;
    logic [31:0] m_out[2];
    logic [3:0]  m_fl[2];
    // DUT observations
    int          obs_cyc[$];
    int          obs_id[$];
    int          obs_rsp;

    function automatic logic [35:0] alu_fn(input logic [5:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
        logic [31:0] r;
        logic ovf, con, err;
        ovf = 1'b0; con = 1'b0; err = 1'b0;
        case (op)
            6'd27:   begin r = x + y; ovf = (x[31] == y[31]) && (r[31] != x[31]); end
            6'd28:   begin r = x - y; ovf = (x[31] != y[31]) && (r[31] != x[31]); end
            6'd4:    begin r = x - y; con = (x == y); end
            6'd63:   begin r = 32'd0; err = 1'b1; end
            default: r = x ^ y;
        endcase
        return {r, err, (r == 32'd0), con, ovf};
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return 6'd27;
            1:       return 6'd28;
            2:       return 6'd4;
            3:       return 6'd9;
            default: return 6'd63;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic new_op(input int n);
        v[n]   = 1'b1;
        a[n]   = $urandom;
        b[n]   = ($urandom_range(0, 3) == 0) ? a[n] : $urandom;
        ins[n] = pick_op();
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit do_chk);
        bit          fire, stray, free, grant, issue;
        int          gid;
        logic [35:0] r;
        logic [31:0] aout;
        logic [3:0]  afl;

        fire  = (alu_cnt == 0) && !alu_sup;
        stray = !fire && stray_en && (alu_cnt < 0) && !(m_busy && !m_resp && m_age >= 2)
                && ($urandom_range(0, 3) == 0);
        if (fire) begin
            aout = alu_res;
            afl  = alu_fl;
        end else begin
            aout = $urandom;
            afl  = 4'($urandom);
        end
        bus.ALU_accept = (ph == 0);
        bus.ALU_ready  = fire || stray;
        bus.ALU_out    = aout;
        {bus.ALU_err, bus.ALU_zero, bus.ALU_con_met, bus.ALU_overflow} = afl;
        bus.req0_valid = v[0]; bus.req0_dat1 = a[0]; bus.req0_dat2 = b[0]; bus.req0_instr = ins[0];
        bus.req1_valid = v[1]; bus.req1_dat1 = a[1]; bus.req1_dat2 = b[1]; bus.req1_instr = ins[1];
        bus.rsp0_ready = rr[0];
        bus.rsp1_ready = rr[1];
        #1;

        free  = !m_busy || (m_resp && rr[m_owner]);
        grant = !reset && free && (ph == 0) && (v[0] || v[1]);
        gid   = (v[0] && v[1]) ? m_prio : (v[1] ? 1 : 0);
        issue = m_busy && !m_resp && (m_age == 1);

        if (bus.req0_ready === 1'b1) begin obs_cyc.push_back(cyc); obs_id.push_back(0); end
        if (bus.req1_ready === 1'b1) begin obs_cyc.push_back(cyc); obs_id.push_back(1); end
        if ((bus.rsp0_valid === 1'b1) || (bus.rsp1_valid === 1'b1)) obs_rsp++;

        if (do_chk) begin
            chk("req0_ready", 32'(bus.req0_ready), 32'(grant && gid == 0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(grant && gid == 1));
            chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_busy && m_resp && m_owner == 0));
            chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_busy && m_resp && m_owner == 1));
            chk("rsp0_out", bus.rsp0_out, m_out[0]);
            chk("rsp1_out", bus.rsp1_out, m_out[1]);
            chk("rsp0_flags", 32'(bus.rsp0_flags), 32'(m_fl[0]));
            chk("rsp1_flags", 32'(bus.rsp1_flags), 32'(m_fl[1]));
            chk("alu_dat1", bus.ALU_dat1, issue ? m_a : 32'd0);
            chk("alu_dat2", bus.ALU_dat2, issue ? m_b : 32'd0);
            chk("alu_instr", 32'(bus.Instruction_from_CU), issue ? 32'(m_i) : 32'd0);
        end

        // ALU stub: result appears two cycles after the issue cycle plus optional stretch
        if (fire) alu_cnt = -1;
        else if (alu_cnt > 0) alu_cnt--;
        if (bus.Instruction_from_CU != 6'd0) begin
            r       = alu_fn(bus.Instruction_from_CU, bus.ALU_dat1, bus.ALU_dat2);
            alu_res = r[35:4];
            alu_fl  = r[3:0];
            alu_cnt = 1 + $urandom_range(0, alu_extra_max);
        end
        ph = (ph + 1) % 4;

        if (reset) begin
            m_busy = 1'b0; m_resp = 1'b0; m_prio = 0; m_owner = 0; m_age = 0;
            m_out[0] = '0; m_out[1] = '0; m_fl[0] = '0; m_fl[1] = '0;
        end else begin
            if (m_busy && !m_resp) begin
                if (m_age >= 2 && (fire || stray)) begin
                    m_out[m_owner] = aout;
                    m_fl[m_owner]  = afl;
                    m_resp = 1'b1;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                else if (m_age >= 2 && m_age >= TO) begin
                    m_out[m_owner] = 32'd0;
                    m_fl[m_owner]  = 4'b1000;
                    m_resp = 1'b1;
                end
`endif
                else m_age++;
            end else if (m_busy && m_resp && rr[m_owner]) begin
                m_busy = 1'b0;
                m_resp = 1'b0;
            end
            if (grant) begin
                m_busy = 1'b1; m_resp = 1'b0; m_age = 1; m_owner = gid;
                m_a = a[gid]; m_b = b[gid]; m_i = ins[gid];
                m_prio = 1 - gid;
            end
        end

        // requesters; operands are scrambled after a grant
        if (grant) begin
            if (auto_new) new_op(gid);
            else begin v[gid] = 1'b0; a[gid] = $urandom; b[gid] = $urandom; end
        end
        if (rand_v) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && $urandom_range(0, 3) == 0) new_op(n);
                else if (v[n] && !(grant && gid == n) && $urandom_range(0, 7) == 0) v[n] = 1'b0;
            end
        end
        if (rr_rand) begin
            rr[0] = 1'($urandom_range(0, 1));
            rr[1] = 1'($urandom_range(0, 1));
        end
        cyc++;
        @(negedge soc_clk);
    endtask

    task automatic drain();
        v[0] = 1'b0; v[1] = 1'b0; rand_v = 1'b0; auto_new = 1'b0;
        rr_rand = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1; stray_en = 1'b0;
        for (int k = 0; k < 30 && m_busy; k++) cycle(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t0, n0, rsp0;
        reset = 1'b1;
        v[0] = 1'b0; v[1] = 1'b0; a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
        ins[0] = '0; ins[1] = '0; rr[0] = 1'b1; rr[1] = 1'b1;
        auto_new = 1'b0; rand_v = 1'b0; rr_rand = 1'b0;
        ph = 0; alu_cnt = -1; alu_extra_max = 0; alu_sup = 1'b0; stray_en = 1'b0;
        alu_res = '0; alu_fl = '0;
        m_busy = 1'b0; m_resp = 1'b0; m_owner = 0; m_age = 0; m_prio = 0;
        m_a = '0; m_b = '0; m_i = '0;
        m_out[0] = '0; m_out[1] = '0; m_fl[0] = '0; m_fl[1] = '0;
        obs_rsp = 0;
        bus.ALU_accept = 1'b0; bus.ALU_ready = 1'b0; bus.ALU_out = '0;
        {bus.ALU_err, bus.ALU_zero, bus.ALU_con_met, bus.ALU_overflow} = 4'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_dat1 = '0; bus.req0_dat2 = '0; bus.req0_instr = '0;
        bus.req1_dat1 = '0; bus.req1_dat2 = '0; bus.req1_instr = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        @(negedge soc_clk);

        // reset state, with a request pending and ALU phase 0 seen during reset
        v[1] = 1'b1; a[1] = 32'd9; b[1] = 32'd9; ins[1] = 6'd27;
        cycle(0);
        for (int k = 0; k < 5; k++) cycle(1);
        v[1] = 1'b0;
        reset = 1'b0;
        chk("reset_no_grant", 32'(obs_cyc.size()), 32'd0);

        // ADD 5+7 raised while ALU_accept=0: grant at next phase 0, nominal latency
        for (int k = 0; k < 4 && ph != 1; k++) cycle(1);
        t0 = cyc;
        v[0] = 1'b1; a[0] = 32'd5; b[0] = 32'd7; ins[0] = 6'd27;
        for (int k = 0; k < 10 && v[0]; k++) cycle(1);
        chk("first_grant_seen", 32'(obs_cyc.size()), 32'd1);
        if (obs_cyc.size() > 0) chk("grant_at_accept", 32'(obs_cyc[$] - t0), 32'd3);
        chk("add_alu_dat1", bus.ALU_dat1, 32'd5);
        chk("add_alu_dat2", bus.ALU_dat2, 32'd7);
        chk("add_alu_instr", 32'(bus.Instruction_from_CU), 32'd27);
        cycle(1); cycle(1);
        chk("add_rsp_not_early", 32'(bus.rsp0_valid), 32'd0);
        cycle(1);
        chk("add_rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("add_rsp_out", bus.rsp0_out, 32'd12);
        chk("add_rsp_flags", 32'(bus.rsp0_flags), 32'd0);
        cycle(1);

        // both requesters continuously valid: strict alternation at 4-cycle spacing
        n0 = obs_cyc.size();
        auto_new = 1'b1;
        new_op(0); new_op(1);
        for (int k = 0; k < 40; k++) cycle(1);
        chk("rr_grant_count", 32'(obs_cyc.size() - n0 >= 8), 32'd1);
        for (int k = 0; k < 8 && n0 + k < obs_cyc.size(); k++) begin
            chk("rr_grant_id", 32'(obs_id[n0 + k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k > 0) chk("rr_spacing", 32'(obs_cyc[n0 + k] - obs_cyc[n0 + k - 1]), 32'd4);
        end
        drain();

        // BEQ 3,3 from req1 with its response held for 5 cycles while req0 waits
        rr[1] = 1'b0;
        v[1] = 1'b1; a[1] = 32'd3; b[1] = 32'd3; ins[1] = 6'd4;
        for (int k = 0; k < 8 && v[1]; k++) cycle(1);
        for (int k = 0; k < 8 && !m_resp; k++) cycle(1);
        new_op(0);
        n0 = obs_cyc.size();
        for (int k = 0; k < 5; k++) begin
            chk("beq_hold_valid", 32'(bus.rsp1_valid), 32'd1);
            chk("beq_hold_out", bus.rsp1_out, 32'd0);
            chk("beq_hold_flags", 32'(bus.rsp1_flags), 32'b0110);
            chk("beq_other_valid", 32'(bus.rsp0_valid), 32'd0);
            cycle(1);
        end
        chk("beq_no_grant_held", 32'(obs_cyc.size() - n0), 32'd0);
        rr[1] = 1'b1;
        for (int k = 0; k < 8 && v[0]; k++) cycle(1);
        chk("beq_release_grant", 32'(obs_cyc.size() - n0), 32'd1);
        drain();

        // reset two cycles after granting a SUB: nothing delivered
        v[0] = 1'b1; a[0] = 32'd100; b[0] = 32'd40; ins[0] = 6'd28;
        for (int k = 0; k < 8 && v[0]; k++) cycle(1);
        cycle(1);
        reset = 1'b1;
        rsp0 = obs_rsp;
        cycle(1);
        reset = 1'b0;
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_rsp0_out", bus.rsp0_out, 32'd0);
        chk("rst_alu_dat1", bus.ALU_dat1, 32'd0);
        chk("rst_alu_instr", 32'(bus.Instruction_from_CU), 32'd0);
        for (int k = 0; k < 8; k++) cycle(1);
        chk("rst_no_response", 32'(obs_rsp - rsp0), 32'd0);

        // random traffic: drops, operand churn, response backpressure, slow ALU, stray ALU_ready
        rand_v = 1'b1; rr_rand = 1'b1; alu_extra_max = 2; stray_en = 1'b1;
        for (int k = 0; k < 400; k++) cycle(1);
        drain();
        alu_extra_max = 0;

        // ALU never answers
        alu_sup = 1'b1;
        v[0] = 1'b1; a[0] = 32'd1; b[0] = 32'd2; ins[0] = 6'd27;
        for (int k = 0; k < 8 && v[0]; k++) cycle(1);
`ifdef ALU_ARB_TIMEOUT_EN
        for (int k = 0; k < TO - 1; k++) cycle(1);
        chk("to_not_early", 32'(bus.rsp0_valid), 32'd0);
        cycle(1);
        chk("to_rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("to_rsp_out", bus.rsp0_out, 32'd0);
        chk("to_rsp_flags", 32'(bus.rsp0_flags), 32'b1000);
        cycle(1);
        alu_cnt = -1;
        alu_sup = 1'b0;
`else
        rsp0 = obs_rsp;
        for (int k = 0; k < 20; k++) cycle(1);
        chk("wait_persists", 32'(obs_rsp - rsp0), 32'd0);
        alu_sup = 1'b0;
        cycle(1);
        chk("late_rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("late_rsp_out", bus.rsp0_out, 32'd3);
`endif
        drain();
        for (int k = 0; k < 4; k++) cycle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
